// File: rtl/vending_pkg.sv
// Shared vending types: coin codes, acceptor states and audit helpers.
// Used by coin_acceptor and the downstream vending FSM.
package vending_pkg;

  localparam int unsigned CODE_W  = 2;
  localparam int unsigned AUDIT_W = 16;

  typedef logic [CODE_W-1:0] coin_code_t;

  localparam coin_code_t COIN_NONE = 2'b00;
  localparam coin_code_t COIN_5    = 2'b01;
  localparam coin_code_t COIN_10   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_EMIT     = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_JAM      = 3'd4
  } acc_state_e;

  typedef enum logic {
    SLOT_5  = 1'b0,
    SLOT_10 = 1'b1
  } coin_slot_e;

  // Synchronised sensor pair.
  typedef struct packed {
    logic s10;
    logic s5;
  } sns_t;

  function automatic coin_code_t slot_code(input coin_slot_e slot);
    return (slot == SLOT_10) ? COIN_10 : COIN_5;
  endfunction

  // Saturating add of the coin value to the audit accumulator.
  function automatic logic [AUDIT_W-1:0] audit_add(input logic [AUDIT_W-1:0] acc,
                                                    input coin_code_t        code);
    logic [AUDIT_W:0] sum;
    logic [AUDIT_W:0] inc;
    case (code)
      COIN_5:  inc = (AUDIT_W+1)'(5);
      COIN_10: inc = (AUDIT_W+1)'(10);
      default: inc = '0;
    endcase
    sum = {1'b0, acc} + inc;
    return sum[AUDIT_W] ? {AUDIT_W{1'b1}} : sum[AUDIT_W-1:0];
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor/handshake bundle between the slot sensors, coin_acceptor and the vending FSM.
// audit_total exists only when COIN_AUDIT_EN is defined.
interface coin_acceptor_if;
  import vending_pkg::*;

  logic       sns_5;
  logic       sns_10;
  logic       accept_en;
  coin_code_t coin_code;
  logic       coin_reject;
  logic       jam;
`ifdef COIN_AUDIT_EN
  logic [AUDIT_W-1:0] audit_total;

  modport master (output sns_5, sns_10, accept_en,
                  input  coin_code, coin_reject, jam, audit_total);
  modport slave  (input  sns_5, sns_10, accept_en,
                  output coin_code, coin_reject, jam, audit_total);
`else
  modport master (output sns_5, sns_10, accept_en,
                  input  coin_code, coin_reject, jam);
  modport slave  (input  sns_5, sns_10, accept_en,
                  output coin_code, coin_reject, jam);
`endif
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one raw asynchronous sensor level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin slot acceptor: synchronise, debounce and classify Rs 5 / Rs 10 coins.
// Optional running coin total enabled by defining COIN_AUDIT_EN.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  coin_acceptor_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sns_t sns;

  sync_2ff u_sync_5 (
    .clk (clk),
    .rst (rst),
    .d   (bus.sns_5),
    .q   (sns.s5)
  );

  sync_2ff u_sync_10 (
    .clk (clk),
    .rst (rst),
    .d   (bus.sns_10),
    .q   (sns.s10)
  );

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  coin_slot_e       slot_q, slot_d;
  coin_code_t       code_q, code_d;
  logic             reject_q, reject_d;
  logic             jam_q, jam_d;

  logic             latched_hi;
  logic             other_hi;
  logic             cnt_hit;

  // The counter is cleared whenever it reaches CNT_MAX, so it never wraps.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    code_d     = COIN_NONE;
    reject_d   = 1'b0;
    latched_hi = (slot_q == SLOT_10) ? sns.s10 : sns.s5;
    other_hi   = (slot_q == SLOT_10) ? sns.s5  : sns.s10;
    cnt_hit    = ((cnt_q + CNT_ONE) == CNT_MAX);

    case (state_q)
      ST_IDLE: begin
        if (sns.s5 && sns.s10) begin
          state_d = ST_JAM;
          cnt_d   = '0;
        end else if (sns.s5 || sns.s10) begin
          state_d = ST_DEBOUNCE;
          slot_d  = sns.s10 ? SLOT_10 : SLOT_5;
          cnt_d   = CNT_ONE;
        end
      end

      ST_DEBOUNCE: begin
        if (other_hi) begin
          state_d = ST_JAM;
          cnt_d   = '0;
        end else if (!latched_hi) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_hit) begin
          state_d = ST_EMIT;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      ST_EMIT: begin
        if (bus.accept_en) begin
          code_d   = slot_code(slot_q);
        end else begin
          reject_d = 1'b1;
        end
        state_d = ST_RELEASE;
        cnt_d   = '0;
      end

      // Both exits wait for a quiet slot; any high sample restarts the wait.
      ST_RELEASE, ST_JAM: begin
        if (sns.s5 || sns.s10) begin
          cnt_d   = '0;
        end else if (cnt_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    jam_d = (state_d == ST_JAM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      slot_q   <= SLOT_5;
      code_q   <= COIN_NONE;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      code_q   <= code_d;
      reject_q <= reject_d;
      jam_q    <= jam_d;
    end
  end

  assign bus.coin_code   = code_q;
  assign bus.coin_reject = reject_q;
  assign bus.jam         = jam_q;

`ifdef COIN_AUDIT_EN
  logic [AUDIT_W-1:0] audit_q, audit_d;

  // Credited on the same edge that raises coin_code.
  always_comb begin
    audit_d = audit_add(audit_q, code_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audit_q <= '0;
    end else begin
      audit_q <= audit_d;
    end
  end

  assign bus.audit_total = audit_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor with DEBOUNCE_CYCLES = 4.
// Audit saturation checks run only when COIN_AUDIT_EN is defined.
module tb_coin_acceptor;
  import vending_pkg::*;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LAT  = DEB + 3;

  logic clk = 1'b0;
  logic rst;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  coin_acceptor_if bus ();

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise one sensor for 'hold' sampling edges, then check every cycle up to 'cycles'.
  task automatic run_coin(input bit is10, input bit acc, input int hold, input int cycles,
                          input bit pulse, input string tag);
    coin_code_t exp_code;
    bit         exp_rej;
    if (is10) bus.sns_10 = 1'b1;
    else      bus.sns_5  = 1'b1;
    bus.accept_en = acc;
    for (int e = 1; e <= cycles; e++) begin
      tick();
      if (e == hold) begin
        bus.sns_5  = 1'b0;
        bus.sns_10 = 1'b0;
      end
      exp_code = (pulse && acc && e == LAT) ? (is10 ? COIN_10 : COIN_5) : COIN_NONE;
      exp_rej  = pulse && !acc && e == LAT;
      check_eq($sformatf("%s_code_e%0d", tag, e), 32'(bus.coin_code), 32'(exp_code));
      check_eq($sformatf("%s_rej_e%0d", tag, e), 32'(bus.coin_reject), 32'(exp_rej));
    end
    check_eq({tag, "_idle"}, 32'(dut.state_q), 32'(ST_IDLE));
    bus.accept_en = 1'b1;
  endtask

`ifdef COIN_AUDIT_EN
  task automatic feed_coin(input bit is10);
    if (is10) bus.sns_10 = 1'b1;
    else      bus.sns_5  = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 6) begin
        bus.sns_5  = 1'b0;
        bus.sns_10 = 1'b0;
      end
    end
  endtask
`endif

  initial begin
`ifdef COIN_AUDIT_EN
    int unsigned audit_before;
`endif
    rst           = 1'b1;
    bus.sns_5     = 1'b0;
    bus.sns_10    = 1'b0;
    bus.accept_en = 1'b1;
    tick();
    tick();
    check_eq("rst_code",  32'(bus.coin_code),   32'(COIN_NONE));
    check_eq("rst_rej",   32'(bus.coin_reject), 0);
    check_eq("rst_jam",   32'(bus.jam),         0);
    check_eq("rst_state", 32'(dut.state_q),     32'(ST_IDLE));
`ifdef COIN_AUDIT_EN
    check_eq("rst_audit", 32'(bus.audit_total), 0);
`endif
    rst = 1'b0;
    tick();

    // Clean Rs 5 coin, accepted.
    run_coin(1'b0, 1'b1, 10, 16, 1'b1, "acc5");

    // Short Rs 10 glitch: no pulse, back to idle.
    run_coin(1'b1, 1'b1, 2, 12, 1'b0, "glitch");

    // Rs 10 with accept_en low: reject pulse, no code, no audit credit.
`ifdef COIN_AUDIT_EN
    audit_before = 32'(bus.audit_total);
`endif
    run_coin(1'b1, 1'b0, 10, 16, 1'b1, "rej10");
`ifdef COIN_AUDIT_EN
    check_eq("rej10_audit", 32'(bus.audit_total), audit_before);
`endif

    // accept_en only matters on the EMIT evaluation edge.
    bus.accept_en = 1'b0;
    bus.sns_5     = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 5)  bus.accept_en = 1'b1;
      if (e == 7)  bus.accept_en = 1'b0;
      if (e == 10) bus.sns_5 = 1'b0;
      if (e == 12) bus.accept_en = 1'b1;
      check_eq($sformatf("aen_code_e%0d", e), 32'(bus.coin_code), (e == 7) ? 32'(COIN_5) : 0);
      check_eq($sformatf("aen_rej_e%0d", e), 32'(bus.coin_reject), 0);
    end
    bus.accept_en = 1'b1;

    // Both sensors for 6 samples: jam from edge 3 through edge 11, no pulses.
    bus.sns_5  = 1'b1;
    bus.sns_10 = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 6) begin
        bus.sns_5  = 1'b0;
        bus.sns_10 = 1'b0;
      end
      check_eq($sformatf("jam_e%0d", e), 32'(bus.jam), (e >= 3 && e <= 11) ? 1 : 0);
      check_eq($sformatf("jam_code_e%0d", e), 32'(bus.coin_code), 32'(COIN_NONE));
      check_eq($sformatf("jam_rej_e%0d", e), 32'(bus.coin_reject), 0);
    end
    check_eq("jam_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Reset in the middle of debouncing an Rs 10 coin; sensor stays high.
    bus.sns_10 = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    check_eq("mid_deb_state", 32'(dut.state_q), 32'(ST_DEBOUNCE));
    rst = 1'b1;
    #1;
    check_eq("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_eq($sformatf("mid_rst_code_e%0d", e), 32'(bus.coin_code), 32'(COIN_NONE));
      check_eq($sformatf("mid_rst_rej_e%0d", e), 32'(bus.coin_reject), 0);
    end
    rst = 1'b0;
    run_coin(1'b1, 1'b1, 10, 16, 1'b1, "post_rst");

`ifdef COIN_AUDIT_EN
    // Saturation: restart from zero, 6553 Rs 10 coins, one more Rs 10, then Rs 5.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("sat_start", 32'(bus.audit_total), 0);
    for (int i = 0; i < 6553; i++) feed_coin(1'b1);
    check_eq("sat_65530", 32'(bus.audit_total), 65530);
    feed_coin(1'b1);
    check_eq("sat_10",    32'(bus.audit_total), 65535);
    feed_coin(1'b0);
    check_eq("sat_5",     32'(bus.audit_total), 65535);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
